// File: rtl/alu_exec.sv
// alu_exec: multi-cycle execute/write-back stage for a 4-entry register file.
// Captures two operands, computes (or shift-add multiplies), writes back with carry/zero.
module alu_exec #(
  parameter int W  = 9,
  parameter int AW = 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [2:0]    op,
  input  logic [AW-1:0] src0,
  input  logic [AW-1:0] src1,
  input  logic [AW-1:0] dst,
  output logic [AW-1:0] rd0_addr,
  output logic [AW-1:0] rd1_addr,
  input  logic [W-1:0]  rd0_data,
  input  logic [W-1:0]  rd1_data,
  output logic          wr_en,
  output logic [AW-1:0] wr_addr,
  output logic [W-1:0]  wr_data,
  output logic          busy,
  output logic          done,
  output logic          carry,
  output logic          zero
);

  // state | meaning
  // IDLE  | waiting for start; request fields latched on acceptance
  // READ  | register file addressed, operands captured at end of cycle
  // EXEC  | single-cycle ALU result, registered into write-back outputs
  // MUL   | one shift-add step per cycle, bit index counting down to 0
  // WB    | write pulse and done presented, flags already updated
  typedef enum logic [2:0] {
    S_IDLE,
    S_READ,
    S_EXEC,
    S_MUL,
    S_WB
  } state_t;

  localparam logic [3:0] CNT_TOP = 4'(W - 1);

  state_t          state_q, state_d;
  logic [2:0]      op_q, op_d;
  logic [AW-1:0]   rd0_addr_q, rd0_addr_d;
  logic [AW-1:0]   rd1_addr_q, rd1_addr_d;
  logic [AW-1:0]   wr_addr_q, wr_addr_d;
  logic [W-1:0]    a_q, a_d;
  logic [W-1:0]    b_q, b_d;
  logic [2*W-1:0]  acc_q, acc_d;
  logic [3:0]      cnt_q, cnt_d;
  logic [W-1:0]    wr_data_q, wr_data_d;
  logic            wr_en_q, wr_en_d;
  logic            done_q, done_d;
  logic            busy_q, busy_d;
  logic            carry_q, carry_d;
  logic            zero_q, zero_d;

  logic [W:0]      alu_full;
  logic            alu_carry;
  logic [2*W-1:0]  acc_next;

  always_comb begin
    alu_full  = '0;
    alu_carry = 1'b0;
    case (op_q)
      3'b000: begin
        alu_full  = {1'b0, a_q} + {1'b0, b_q};
        alu_carry = alu_full[W];
      end
      3'b001: begin
        // bit W of the widened difference is the borrow (A < B)
        alu_full  = {1'b0, a_q} - {1'b0, b_q};
        alu_carry = alu_full[W];
      end
      3'b010: alu_full = {1'b0, a_q & b_q};
      3'b011: alu_full = {1'b0, a_q | b_q};
      3'b100: alu_full = {1'b0, a_q ^ b_q};
      3'b101: begin
        alu_full  = {1'b0, a_q[W-2:0], 1'b0};
        alu_carry = a_q[W-1];
      end
      3'b110: begin
        alu_full  = {2'b00, a_q[W-1:1]};
        alu_carry = a_q[0];
      end
      default: begin
        alu_full  = '0;
        alu_carry = 1'b0;
      end
    endcase
  end

  assign acc_next = acc_q + (b_q[cnt_q] ? ({{W{1'b0}}, a_q} << cnt_q) : '0);

  always_comb begin
    state_d    = state_q;
    op_d       = op_q;
    rd0_addr_d = rd0_addr_q;
    rd1_addr_d = rd1_addr_q;
    wr_addr_d  = wr_addr_q;
    a_d        = a_q;
    b_d        = b_q;
    acc_d      = acc_q;
    cnt_d      = cnt_q;
    wr_data_d  = wr_data_q;
    wr_en_d    = 1'b0;
    done_d     = 1'b0;
    busy_d     = busy_q;
    carry_d    = carry_q;
    zero_d     = zero_q;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          op_d       = op;
          rd0_addr_d = src0;
          rd1_addr_d = src1;
          wr_addr_d  = dst;
          busy_d     = 1'b1;
          state_d    = S_READ;
        end
      end
      S_READ: begin
        a_d     = rd0_data;
        b_d     = rd1_data;
        acc_d   = '0;
        cnt_d   = CNT_TOP;
        state_d = (op_q == 3'b111) ? S_MUL : S_EXEC;
      end
      S_EXEC: begin
        wr_data_d = alu_full[W-1:0];
        carry_d   = alu_carry;
        zero_d    = (alu_full[W-1:0] == '0);
        wr_en_d   = 1'b1;
        done_d    = 1'b1;
        state_d   = S_WB;
      end
      S_MUL: begin
        acc_d = acc_next;
        if (cnt_q == '0) begin
          wr_data_d = acc_next[W-1:0];
          carry_d   = |acc_next[2*W-1:W];
          zero_d    = (acc_next[W-1:0] == '0);
          wr_en_d   = 1'b1;
          done_d    = 1'b1;
          state_d   = S_WB;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      S_WB: begin
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
      default: begin
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      op_q       <= '0;
      rd0_addr_q <= '0;
      rd1_addr_q <= '0;
      wr_addr_q  <= '0;
      a_q        <= '0;
      b_q        <= '0;
      acc_q      <= '0;
      cnt_q      <= '0;
      wr_data_q  <= '0;
      wr_en_q    <= 1'b0;
      done_q     <= 1'b0;
      busy_q     <= 1'b0;
      carry_q    <= 1'b0;
      zero_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      op_q       <= op_d;
      rd0_addr_q <= rd0_addr_d;
      rd1_addr_q <= rd1_addr_d;
      wr_addr_q  <= wr_addr_d;
      a_q        <= a_d;
      b_q        <= b_d;
      acc_q      <= acc_d;
      cnt_q      <= cnt_d;
      wr_data_q  <= wr_data_d;
      wr_en_q    <= wr_en_d;
      done_q     <= done_d;
      busy_q     <= busy_d;
      carry_q    <= carry_d;
      zero_q     <= zero_d;
    end
  end

  assign rd0_addr = rd0_addr_q;
  assign rd1_addr = rd1_addr_q;
  assign wr_addr  = wr_addr_q;
  assign wr_data  = wr_data_q;
  assign wr_en    = wr_en_q;
  assign done     = done_q;
  assign busy     = busy_q;
  assign carry    = carry_q;
  assign zero     = zero_q;

endmodule
